spinnaker_fpgas_spi_reg_sequencer: RTL

//  Sequences SPI peek/poke transactions onto the HSS register address decoder.

---
 rtl/spinnaker_fpgas_spi_reg_sequencer_pkg.sv | 10 +
 rtl/spinnaker_fpgas_spi_word_shifter.sv | 18 +
 rtl/spinnaker_fpgas_spi_reg_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/spinnaker_fpgas_spi_reg_sequencer_pkg.sv
// spinnaker_fpgas_spi_reg_sequencer_pkg: opcodes, FSM states and device-select codes for the SPI register sequencer
package spinnaker_fpgas_spi_reg_sequencer_pkg;
  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;
  typedef enum logic [1:0] {DEV_B2B0 = 2'b00, DEV_B2B1 = 2'b01, DEV_PERIPH = 2'b10, DEV_RING = 2'b11} dev_sel_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/spinnaker_fpgas_spi_word_shifter.sv
// spinnaker_fpgas_spi_word_shifter: word register with parallel load and MSB-first byte shift
module spinnaker_fpgas_spi_word_shifter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word
);
  // load wins over shift; a shift moves the word up one byte and appends byte_in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word <= '0;
    else if (load) word <= load_val;
    else if (shift) word <= (word << 8) | W'(byte_in);
endmodule

// File: rtl/spinnaker_fpgas_spi_reg_sequencer.sv
// spinnaker_fpgas_spi_reg_sequencer: turns SPI peek/poke frames into single read/write strobes
module spinnaker_fpgas_spi_reg_sequencer
  import spinnaker_fpgas_spi_reg_sequencer_pkg::*;
#(
  parameter int ADDR_BITS    = 32,
  parameter int VAL_BITS     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_N_IN,
  input  logic                 FRAME_IN,
  input  logic [7:0]           RX_DATA_IN,
  input  logic                 RX_VLD_IN,
  output logic [7:0]           TX_DATA_OUT,
  output logic                 TX_VLD_OUT,
  input  logic                 TX_RDY_IN,
  output logic [ADDR_BITS-1:0] ADDR_OUT,
  output logic [VAL_BITS-1:0]  WRITE_DATA_OUT,
  output logic                 READ_OUT,
  output logic                 WRITE_OUT,
  input  logic [VAL_BITS-1:0]  READ_VALUE_IN,
  output logic                 BUSY_OUT,
  output logic                 ERROR_OUT
);
  localparam int AB = ADDR_BITS / 8;
  localparam int VB = VAL_BITS / 8;
  localparam int CW = $clog2(max_int(ADDR_BITS, VAL_BITS) / 8) + 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lat;
  logic is_write, rx_ok, tx_acc, cap;
  assign rx_ok = RX_VLD_IN && FRAME_IN;
  assign tx_acc = TX_VLD_OUT && TX_RDY_IN && FRAME_IN;
  assign cap = state == S_WAIT && lat == LW'(READ_LATENCY) && FRAME_IN;
  assign BUSY_OUT = state != S_IDLE;
  assign TX_DATA_OUT = WRITE_DATA_OUT[VAL_BITS-1 -: 8];
  spinnaker_fpgas_spi_word_shifter #(.W(ADDR_BITS)) u_addr (
    .clk(CLK_IN), .rst_n(RESET_N_IN), .load(1'b0), .load_val('0),
    .shift(state == S_ADDR && rx_ok), .byte_in(RX_DATA_IN), .word(ADDR_OUT)
  );
  // one register serves write data in and the read response out
  spinnaker_fpgas_spi_word_shifter #(.W(VAL_BITS)) u_data (
    .clk(CLK_IN), .rst_n(RESET_N_IN), .load(cap), .load_val(READ_VALUE_IN),
    .shift((state == S_WDATA && rx_ok) || (state == S_RESP && tx_acc)),
    .byte_in(state == S_RESP ? 8'h00 : RX_DATA_IN), .word(WRITE_DATA_OUT)
  );
  // transaction FSM; strobes and error are one-cycle registered pulses, frame end aborts everything
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) begin
      state <= S_IDLE;
      cnt <= '0;
      lat <= '0;
      is_write <= 1'b0;
      TX_VLD_OUT <= 1'b0;
      READ_OUT <= 1'b0;
      WRITE_OUT <= 1'b0;
      ERROR_OUT <= 1'b0;
    end else begin
      READ_OUT <= 1'b0;
      WRITE_OUT <= 1'b0;
      ERROR_OUT <= 1'b0;
      if (!FRAME_IN) begin
        state <= S_IDLE;
        cnt <= '0;
        lat <= '0;
        TX_VLD_OUT <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (RX_VLD_IN) begin
              if (RX_DATA_IN == CMD_READ || RX_DATA_IN == CMD_WRITE) begin
                is_write <= RX_DATA_IN == CMD_WRITE;
                state <= S_ADDR;
              end else begin
                ERROR_OUT <= 1'b1;
                state <= S_DRAIN;
              end
            end
          S_ADDR:
            if (RX_VLD_IN) begin
              if (cnt == CW'(AB - 1)) begin
                cnt <= '0;
                state <= is_write ? S_WDATA : S_ISSUE;
                READ_OUT <= !is_write;
              end else cnt <= cnt + 1'b1;
            end
          S_WDATA:
            if (RX_VLD_IN) begin
              if (cnt == CW'(VB - 1)) begin
                cnt <= '0;
                state <= S_ISSUE;
                WRITE_OUT <= 1'b1;
              end else cnt <= cnt + 1'b1;
            end
          S_ISSUE: begin
            state <= is_write ? S_DRAIN : S_WAIT;
            lat <= LW'(1);
          end
          S_WAIT:
            if (cap) begin
              state <= S_RESP;
              TX_VLD_OUT <= 1'b1;
            end else lat <= lat + 1'b1;
          S_RESP:
            if (tx_acc) begin
              if (cnt == CW'(VB - 1)) begin
                cnt <= '0;
                TX_VLD_OUT <= 1'b0;
                state <= S_DRAIN;
              end else cnt <= cnt + 1'b1;
            end
          default: ;
        endcase
    end
endmodule
